// File: rtl/skolem_cex_scanner_pkg.sv
// Shared types and slice-offset helpers for the Skolem counterexample scanner.
package skolem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_Y,
    CHECK,
    NEXT_X,
    FIN
  } state_t;

  // Start bit of clause idx inside a flattened clause mask bus.
  function automatic int unsigned clause_off(input int unsigned idx, input int unsigned nv);
    return idx * nv;
  endfunction

  // Start bit of cube (yi, ti) inside a flattened a_/c_ literal mask bus.
  function automatic int unsigned cube_off(input int unsigned yi, input int unsigned ti,
                                           input int unsigned nt, input int unsigned nx);
    return (yi * nt + ti) * nx;
  endfunction

endpackage

// File: rtl/skolem_cex_scanner_if.sv
// Formula/handshake/result bundle between a controller (master) and the scanner (slave).
interface skolem_cex_scanner_if #(
  parameter int NUM_X       = 2,
  parameter int NUM_Y       = 2,
  parameter int NUM_CLAUSES = 4,
  parameter int NUM_TERMS   = 2
);
  localparam int NV    = NUM_X + NUM_Y;
  localparam int CUBES = NUM_Y * NUM_TERMS;

  logic                         start;
  logic [NUM_CLAUSES-1:0]       clause_en;
  logic [NUM_CLAUSES*NV-1:0]    clause_pos;
  logic [NUM_CLAUSES*NV-1:0]    clause_neg;
  logic [CUBES-1:0]             a_term_en;
  logic [CUBES-1:0]             c_term_en;
  logic [CUBES*NUM_X-1:0]       a_pos;
  logic [CUBES*NUM_X-1:0]       a_neg;
  logic [CUBES*NUM_X-1:0]       c_pos;
  logic [CUBES*NUM_X-1:0]       c_neg;
  logic [NUM_Y-1:0]             g;
  logic                         busy;
  logic                         done;
  logic                         cex_found;
  logic [NUM_X-1:0]             cex_x;
  logic [NUM_Y-1:0]             cex_g;
  logic [NUM_Y-1:0]             cex_y;

  modport master (
    output start, clause_en, clause_pos, clause_neg, a_term_en, c_term_en,
           a_pos, a_neg, c_pos, c_neg, g,
    input  busy, done, cex_found, cex_x, cex_g, cex_y
  );

  modport slave (
    input  start, clause_en, clause_pos, clause_neg, a_term_en, c_term_en,
           a_pos, a_neg, c_pos, c_neg, g,
    output busy, done, cex_found, cex_x, cex_g, cex_y
  );

endinterface

// File: rtl/skolem_cnf_eval.sv
// Combinational CNF evaluator: true iff every enabled clause has a satisfied literal.
module skolem_cnf_eval
  import skolem_pkg::*;
#(
  parameter int NUM_CLAUSES = 4,
  parameter int NV          = 4
) (
  input  logic [NUM_CLAUSES-1:0]    clause_en_i,
  input  logic [NUM_CLAUSES*NV-1:0] clause_pos_i,
  input  logic [NUM_CLAUSES*NV-1:0] clause_neg_i,
  input  logic [NV-1:0]             v_i,
  output logic                      valid_o
);

  always_comb begin
    // NOTE: default first so every path assigns valid_o and no latch is inferred.
    valid_o = 1'b1;
    for (int k = 0; k < NUM_CLAUSES; k++) begin
      if (clause_en_i[k] &&
          !((|(clause_pos_i[clause_off(k, NV) +: NV] & v_i)) ||
            (|(clause_neg_i[clause_off(k, NV) +: NV] & ~v_i)))) begin
        valid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/skolem_cex_scanner.sv
// Exhaustive Skolem-vector miter: reports the first x where F is satisfiable but F(x,y_syn) is not.
// Build option SKOLEM_G_ENUM_EN: enumerate every g internally instead of using the g port.
module skolem_cex_scanner
  import skolem_pkg::*;
#(
  parameter int NUM_X       = 2,
  parameter int NUM_Y       = 2,
  parameter int NUM_CLAUSES = 4,
  parameter int NUM_TERMS   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  skolem_cex_scanner_if.slave  bus
);

  localparam int NV = NUM_X + NUM_Y;

  state_t           state_q, state_d;
  logic [NUM_X-1:0] x_q, x_d;
  logic [NUM_Y-1:0] y_q, y_d;
  logic [NUM_Y-1:0] wit_q, wit_d;
  logic             cex_found_q, cex_found_d;
  logic [NUM_X-1:0] cex_x_q, cex_x_d;
  logic [NUM_Y-1:0] cex_g_q, cex_g_d;
  logic [NUM_Y-1:0] cex_y_q, cex_y_d;
  logic [NUM_Y-1:0] g_eff;
  logic [NUM_Y-1:0] a_val, c_val, y_syn;
  logic             f_search, f_syn;
  logic             busy, done;

`ifdef SKOLEM_G_ENUM_EN
  logic [NUM_Y-1:0] g_q, g_d;
  assign g_eff = g_q;
`else
  assign g_eff = bus.g;
`endif

  function automatic logic cube_hit(input logic [NUM_X-1:0] x, input logic [NUM_X-1:0] pos,
                                    input logic [NUM_X-1:0] neg);
    return ((x & pos) == pos) && ((~x & neg) == neg);
  endfunction

  // a_i / c_i as OR of enabled cubes over the current x.
  always_comb begin
    a_val = '0;
    c_val = '0;
    for (int i = 0; i < NUM_Y; i++) begin
      for (int t = 0; t < NUM_TERMS; t++) begin
        if (bus.a_term_en[i*NUM_TERMS+t] &&
            cube_hit(x_q, bus.a_pos[cube_off(i, t, NUM_TERMS, NUM_X) +: NUM_X],
                          bus.a_neg[cube_off(i, t, NUM_TERMS, NUM_X) +: NUM_X]))
          a_val[i] = 1'b1;
        if (bus.c_term_en[i*NUM_TERMS+t] &&
            cube_hit(x_q, bus.c_pos[cube_off(i, t, NUM_TERMS, NUM_X) +: NUM_X],
                          bus.c_neg[cube_off(i, t, NUM_TERMS, NUM_X) +: NUM_X]))
          c_val[i] = 1'b1;
      end
    end
  end

  assign y_syn = a_val | (g_eff & ~c_val);

  skolem_cnf_eval #(.NUM_CLAUSES(NUM_CLAUSES), .NV(NV)) u_cnf_search (
    .clause_en_i  (bus.clause_en),
    .clause_pos_i (bus.clause_pos),
    .clause_neg_i (bus.clause_neg),
    .v_i          ({y_q, x_q}),
    .valid_o      (f_search)
  );

  skolem_cnf_eval #(.NUM_CLAUSES(NUM_CLAUSES), .NV(NV)) u_cnf_syn (
    .clause_en_i  (bus.clause_en),
    .clause_pos_i (bus.clause_pos),
    .clause_neg_i (bus.clause_neg),
    .v_i          ({y_syn, x_q}),
    .valid_o      (f_syn)
  );

  // State register: FSM state plus all scan counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      wit_q       <= '0;
      cex_found_q <= 1'b0;
      cex_x_q     <= '0;
      cex_g_q     <= '0;
      cex_y_q     <= '0;
`ifdef SKOLEM_G_ENUM_EN
      g_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wit_q       <= wit_d;
      cex_found_q <= cex_found_d;
      cex_x_q     <= cex_x_d;
      cex_g_q     <= cex_g_d;
      cex_y_q     <= cex_y_d;
`ifdef SKOLEM_G_ENUM_EN
      g_q         <= g_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    wit_d       = wit_q;
    cex_found_d = cex_found_q;
    cex_x_d     = cex_x_q;
    cex_g_d     = cex_g_q;
    cex_y_d     = cex_y_q;
`ifdef SKOLEM_G_ENUM_EN
    g_d         = g_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SCAN_Y;
          x_d         = '0;
          y_d         = '0;
          cex_found_d = 1'b0;
          cex_x_d     = '0;
          cex_g_d     = '0;
          cex_y_d     = '0;
        end
      end
      SCAN_Y: begin
        if (f_search) begin
          wit_d   = y_q;
          state_d = CHECK;
`ifdef SKOLEM_G_ENUM_EN
          g_d     = '0;
`endif
        end else if (y_q == '1) begin
          state_d = NEXT_X;
        end else begin
          y_d = y_q + 1'b1;
        end
      end
      CHECK: begin
        if (!f_syn) begin
          cex_found_d = 1'b1;
          cex_x_d     = x_q;
          cex_g_d     = g_eff;
          cex_y_d     = wit_q;
          state_d     = FIN;
        end else begin
`ifdef SKOLEM_G_ENUM_EN
          if (g_q == '1) state_d = NEXT_X;
          else           g_d     = g_q + 1'b1;
`else
          state_d = NEXT_X;
`endif
        end
      end
      NEXT_X: begin
        if (x_q == '1) begin
          state_d = FIN;
        end else begin
          x_d     = x_q + 1'b1;
          y_d     = '0;
          state_d = SCAN_Y;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q == SCAN_Y) || (state_q == CHECK) || (state_q == NEXT_X);
    done = (state_q == FIN);
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.cex_found = cex_found_q;
  assign bus.cex_x     = cex_x_q;
  assign bus.cex_g     = cex_g_q;
  assign bus.cex_y     = cex_y_q;

endmodule
